// File: rtl/fifo_wr_pkg.sv
// Shared definitions for the FIFO burst writer: default widths and FSM state encoding.
// CSUM exists only when FIFO_WR_CHECKSUM_EN is defined.
package fifo_wr_pkg;

    localparam int DW_DEFAULT = 8;
    localparam int LW_DEFAULT = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
`ifdef FIFO_WR_CHECKSUM_EN
        CSUM  = 2'd2,
`endif
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/fifo_burst_writer.sv
// Burst writer: pushes len payload words (constant or incrementing from seed) into a FIFO.
// Define FIFO_WR_CHECKSUM_EN to append a mod-2^DW checksum trailer word after the payload.
module fifo_burst_writer
    import fifo_wr_pkg::*;
#(
    parameter int DW = DW_DEFAULT,
    parameter int LW = LW_DEFAULT
) (
    input  logic          clkw,
    input  logic          rst,
    input  logic          start,
    input  logic [LW-1:0] len,
    input  logic [DW-1:0] seed,
    input  logic          inc,
    input  logic          abort,
    input  logic          f,
    output logic          WREQ,
    output logic [DW-1:0] WD,
    output logic          busy,
    output logic          done,
    output logic [LW-1:0] wcount
);

    state_t        r_state;
    state_t        w_next;
    logic [DW-1:0] r_data;
    logic [LW-1:0] r_rem;
    logic [LW-1:0] r_wcount;
    logic          r_inc;
    logic          w_last;
`ifdef FIFO_WR_CHECKSUM_EN
    logic [DW-1:0] r_csum;
`endif

    assign w_last = (r_rem == LW'(1));
    assign WD     = r_data;
    assign wcount = r_wcount;

    always_ff @(posedge clkw or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next = (len == '0) ? DONE : WRITE;
                end
            end
            WRITE: begin
                if (abort) begin
                    w_next = IDLE;
                end else if (WREQ && w_last) begin
`ifdef FIFO_WR_CHECKSUM_EN
                    w_next = CSUM;
`else
                    w_next = DONE;
`endif
                end
            end
`ifdef FIFO_WR_CHECKSUM_EN
            CSUM: begin
                if (abort) begin
                    w_next = IDLE;
                end else if (WREQ) begin
                    w_next = DONE;
                end
            end
`endif
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        WREQ = 1'b0;
        busy = 1'b1;
        done = 1'b0;
        case (r_state)
            IDLE:  busy = 1'b0;
            WRITE: WREQ = !f && !abort;
`ifdef FIFO_WR_CHECKSUM_EN
            CSUM:  WREQ = !f && !abort;
`endif
            DONE:  done = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    // The last payload word does not advance r_data, so WD holds it through DONE/IDLE.
    // With the trailer enabled, r_data is loaded with the final sum so WD presents it in CSUM.
    always_ff @(posedge clkw or negedge rst) begin
        if (!rst) begin
            r_data   <= '0;
            r_rem    <= '0;
            r_inc    <= 1'b0;
            r_wcount <= '0;
`ifdef FIFO_WR_CHECKSUM_EN
            r_csum   <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_wcount <= '0;
                        if (len != '0) begin
                            r_data <= seed;
                            r_rem  <= len;
                            r_inc  <= inc;
`ifdef FIFO_WR_CHECKSUM_EN
                            r_csum <= '0;
`endif
                        end
                    end
                end
                WRITE: begin
                    if (WREQ) begin
                        r_wcount <= r_wcount + LW'(1);
                        r_rem    <= r_rem - LW'(1);
`ifdef FIFO_WR_CHECKSUM_EN
                        r_csum   <= r_csum + r_data;
                        if (w_last) begin
                            r_data <= r_csum + r_data;
                        end else begin
                            r_data <= r_data + DW'(r_inc);
                        end
`else
                        if (!w_last) begin
                            r_data <= r_data + DW'(r_inc);
                        end
`endif
                    end
                end
`ifdef FIFO_WR_CHECKSUM_EN
                CSUM: begin
                    if (WREQ) begin
                        r_wcount <= r_wcount + LW'(1);
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_burst_writer.sv
// Scoreboard bench for fifo_burst_writer: stimulus queues expected FIFO words, a monitor pops them on WREQ.
// Works with or without FIFO_WR_CHECKSUM_EN defined.
module tb_fifo_burst_writer;

`ifdef FIFO_WR_CHECKSUM_EN
    localparam int TRAILER = 1;
`else
    localparam int TRAILER = 0;
`endif

    logic       clkw  = 1'b0;
    logic       rst   = 1'b1;
    logic       start = 1'b0;
    logic [8:0] len   = '0;
    logic [7:0] seed  = '0;
    logic       inc   = 1'b0;
    logic       abort = 1'b0;
    logic       f     = 1'b0;
    logic       WREQ;
    logic [7:0] WD;
    logic       busy;
    logic       done;
    logic [8:0] wcount;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] expQ[$];

    fifo_burst_writer #(.DW(8), .LW(9)) dut (
        .clkw   (clkw),
        .rst    (rst),
        .start  (start),
        .len    (len),
        .seed   (seed),
        .inc    (inc),
        .abort  (abort),
        .f      (f),
        .WREQ   (WREQ),
        .WD     (WD),
        .busy   (busy),
        .done   (done),
        .wcount (wcount)
    );

    always #5 clkw = ~clkw;

    function automatic void checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // Monitor: every accepted write must match the next queued word.
    always @(negedge clkw) begin
        if (rst && WREQ) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected WREQ", 1, 0);
            end else begin
                checkOutput("WD on WREQ", int'(WD), int'(expQ.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clkw);
        #1;
    endtask

    task automatic applyStimulus(input int n, input logic [7:0] s, input logic i);
        logic [7:0] word;
        logic [7:0] sum;
        word = s;
        sum  = '0;
        for (int k = 0; k < n; k++) begin
            expQ.push_back(word);
            sum  = sum + word;
            word = word + {7'd0, i};
        end
        if (TRAILER == 1 && n != 0) expQ.push_back(sum);
        start = 1'b1;
        len   = 9'(n);
        seed  = s;
        inc   = i;
        tick();
        start = 1'b0;
    endtask

    task automatic waitDone(input string name, input int expCycles);
        int cyc;
        bit seen;
        cyc  = 0;
        seen = 0;
        while (!seen && cyc < 40) begin
            @(negedge clkw);
            cyc++;
            if (done) seen = 1;
        end
        checkOutput({name, " done latency"}, seen ? cyc : -1, expCycles);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #1 rst = 1'b0;
        #2;
        checkOutput("reset WREQ", int'(WREQ), 0);
        checkOutput("reset WD", int'(WD), 0);
        checkOutput("reset busy", int'(busy), 0);
        checkOutput("reset done", int'(done), 0);
        checkOutput("reset wcount", int'(wcount), 0);
        tick();
        rst = 1'b1;
        tick();

        // Scenario 1: len=4 incrementing from 0x10
        applyStimulus(4, 8'h10, 1'b1);
        waitDone("s1", 4 + TRAILER + 1);
        checkOutput("s1 wcount", int'(wcount), 4 + TRAILER);
        checkOutput("s1 busy in DONE", int'(busy), 1);
        checkOutput("s1 WD held", int'(WD), TRAILER ? 'h46 : 'h13);
        tick();
        checkOutput("s1 done one cycle", int'(done), 0);
        checkOutput("s1 idle busy", int'(busy), 0);

        // Scenario 2: back-to-back start, wrap through 0xFF
        applyStimulus(3, 8'hFE, 1'b1);
        waitDone("s2", 3 + TRAILER + 1);
        checkOutput("s2 wcount", int'(wcount), 3 + TRAILER);
        checkOutput("s2 WD held", int'(WD), TRAILER ? 'hFD : 'h00);
        tick();

        // Scenario 3: FIFO full during WRITE cycles 2-4
        applyStimulus(5, 8'h30, 1'b1);
        tick();
        f = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clkw);
            checkOutput("s3 stall WREQ", int'(WREQ), 0);
            checkOutput("s3 stall WD", int'(WD), 'h31);
            tick();
        end
        f = 1'b0;
        waitDone("s3", 4 + TRAILER + 1);
        checkOutput("s3 wcount", int'(wcount), 5 + TRAILER);
        tick();

        // Scenario 4: zero-length burst
        applyStimulus(0, 8'h99, 1'b1);
        waitDone("s4", 1);
        checkOutput("s4 wcount", int'(wcount), 0);
        checkOutput("s4 WD held", int'(WD), TRAILER ? 'hFA : 'h34);
        tick();

        // Scenario 5: abort after 3 accepted writes
        applyStimulus(10, 8'h40, 1'b1);
        tick();
        tick();
        tick();
        abort = 1'b1;
        @(negedge clkw);
        checkOutput("s5 abort WREQ", int'(WREQ), 0);
        expQ.delete();
        tick();
        abort = 1'b0;
        checkOutput("s5 busy after abort", int'(busy), 0);
        checkOutput("s5 wcount", int'(wcount), 3);
        for (int k = 0; k < 3; k++) begin
            @(negedge clkw);
            checkOutput("s5 no done", int'(done), 0);
        end
        tick();

        // Scenario 6: reset mid-burst, then a clean len=2 burst
        applyStimulus(8, 8'h80, 1'b1);
        tick();
        tick();
        tick();
        rst = 1'b0;
        #1;
        checkOutput("s6 reset WREQ", int'(WREQ), 0);
        checkOutput("s6 reset WD", int'(WD), 0);
        checkOutput("s6 reset busy", int'(busy), 0);
        checkOutput("s6 reset done", int'(done), 0);
        checkOutput("s6 reset wcount", int'(wcount), 0);
        expQ.delete();
        tick();
        rst = 1'b1;
        @(negedge clkw);
        checkOutput("s6 post-reset WREQ", int'(WREQ), 0);
        tick();
        applyStimulus(2, 8'h05, 1'b1);
        waitDone("s6", 2 + TRAILER + 1);
        checkOutput("s6 wcount", int'(wcount), 2 + TRAILER);
        checkOutput("s6 queue drained", expQ.size(), 0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
